maxpool2x2_stream: RTL and testbench
====================================

// Module: maxpool2x2_stream
// PURPOSE
//  Streaming 2x2/stride-2 FP16 max-pool for CH parallel channel lanes.
//  Consumes a raster-order feature map one pixel (all CH lanes) per handshake.
//  Buffers half a row of horizontal maxima and emits one pooled pixel per 2x2 window.
//  Sits between a conv/activation output stream and the next layer's input stream.
// PARAMETERS
//  IMG_W   24  input map width in pixels; must be even (elaboration $error otherwise)
//  IMG_H   24  input map height in pixels; must be even (elaboration $error otherwise)
//  CH      4   parallel channel lanes; each lane is 16-bit FP16
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  rst_n      in   1       asynchronous reset, active-low
//  in_valid   in   1       input pixel valid
//  in_ready   out  1       block accepts input this cycle
//  in_data    in   CH*16   lane k = in_data[16k+15:16k], FP16
//  out_valid  out  1       pooled pixel valid
//  out_ready  in   1       downstream accepts output this cycle
//  out_data   out  CH*16   pooled lanes, same packing as in_data
//  out_last   out  1       high with the final pooled pixel of a frame
// BEHAVIOUR
//  - Reset (rst_n low, async): col=0, row=0, phase=EVEN, out_valid=0, out_data=0,
//    out_last=0, hold regs=0. in_ready is combinational and therefore 1 during and after reset.
//    Line buffer contents are don't-care.
//  - Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
//  - in_ready = !out_valid | out_ready.
//    Only an odd-row, odd-col beat produces output, but stall is global for simplicity.
//  - Counters: col 0..IMG_W-1 advances per accepted beat. row increments at col wrap.
//    row wraps at IMG_H-1 to 0. phase = row[0] (EVEN/ODD state).
//  - Max semantics per lane use fp16_max_comparator; no new comparison rules:
//    hmax = max(hold, in) for the horizontal pair.
//  - col even: hold <= in_data (per lane).
//  - EVEN row, col odd: linebuf[col>>1] <= hmax. Depth IMG_W/2 x CH*16.
//  - ODD row, col odd: out_data <= max(linebuf[col>>1], hmax). out_valid <= 1.
//    out_last <= (row==IMG_H-1 && col==IMG_W-1).
//  - Latency: out_valid rises the cycle after the 2nd pixel of the odd-row pair is accepted.
//  - out_valid clears on out_ready when no new result loads the same cycle.
//    Simultaneous drain and load: the new result replaces the old; out_valid stays 1.
//  - out_data/out_last hold stable while out_valid & !out_ready.
//  - Throughput: 1 input/cycle sustained with out_ready=1.
//    Output rate: (IMG_W/2)*(IMG_H/2) pixels per IMG_W*IMG_H inputs.
//  - Frame wrap: after the last input, counters return to 0 and the next frame streams back-to-back.
//    No bubble is required.
//  - Reset mid-frame: all counters and the output register clear immediately.
//    A pending output is discarded. The next accepted beat is treated as pixel (0,0).
//  - in_valid low: no state change except output drain.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_last=0, col/row=0.
//    Release -> first beat lands at (0,0).
//  2 IMG_W=4, IMG_H=2, CH=1.
//    Stream 3C00,4000,3800,BC00 / BC00,3C00,4200,3800, out_ready=1
//    -> outputs 4000 then 4200. out_last=1 on 4200 only.
//    Each output appears 1 cycle after its 2nd odd-row pixel.
//  3 Negatives, CH=2: window lane0 {BC00,C000,C200,BE00}, lane1 {0000,8000,BC00,3800}
//    -> lane0 BC00, lane1 3800. Lanes are independent.
//  4 Backpressure: out_ready=0 while a result is pending
//    -> in_ready=0, out_data stable, no input consumed.
//    out_ready=1 -> drains; in_ready returns to 1 the same cycle.
//  5 Back-to-back frames with in_valid=1 continuously, 24x24, random FP16 vs software model
//    -> 144 outputs per frame, exact match.
//    out_last on every 144th output; no idle cycles at the boundary.
//  6 Assert rst_n=0 mid-row 1 with out_valid=1 -> out_valid drops asynchronously.
//    Subsequent frame pools correctly from pixel (0,0).

Source files
------------

// File: rtl/maxpool2x2_stream_if.sv
// Stream bundle for maxpool2x2_stream: raster pixel input and pooled pixel output.
// The master side is the surrounding fabric; the slave side is the pooling block.
interface maxpool2x2_stream_if #(
  parameter int unsigned CH = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [CH*16-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [CH*16-1:0] out_data;
  logic            out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2/stride-2 FP16 max-pool over CH lanes. Keeps half a row of horizontal
// maxima from the even row and emits one pooled pixel per window on the odd row.
module maxpool2x2_stream #(
  parameter int unsigned IMG_W = 24,
  parameter int unsigned IMG_H = 24,
  parameter int unsigned CH    = 4
) (
  input logic                clk,
  input logic                rst_n,
  maxpool2x2_stream_if.slave bus
);

  localparam int unsigned DW   = CH * 16;
  localparam int unsigned HALF = IMG_W / 2;
  localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned LW   = (HALF > 1) ? $clog2(HALF) : 1;

  if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_width
    $error("maxpool2x2_stream: IMG_W must be even and nonzero");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_height
    $error("maxpool2x2_stream: IMG_H must be even and nonzero");
  end

  typedef enum logic {StEven, StOdd} phase_e;

  // Map FP16 onto an unsigned key whose integer order is the numeric order.
  function automatic logic [15:0] fp16_key(input logic [15:0] v);
    return v[15] ? ~v : (v | 16'h8000);
  endfunction

  function automatic logic [15:0] fp16_max(input logic [15:0] a, input logic [15:0] b);
    return (fp16_key(b) > fp16_key(a)) ? b : a;
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  phase_e        phase_q, phase_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic [DW-1:0] linebuf_q [HALF];
  logic [LW-1:0] lb_idx;
  logic [DW-1:0] lb_rd;
  logic          lb_we;

  logic [DW-1:0] hmax, vmax;
  logic          in_ready, accept, col_last, row_last;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign lb_idx   = LW'(col_q >> 1);
  assign lb_rd    = linebuf_q[lb_idx];

  always_comb begin
    hmax = '0;
    vmax = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      hmax[k*16 +: 16] = fp16_max(hold_q[k*16 +: 16], bus.in_data[k*16 +: 16]);
      vmax[k*16 +: 16] = fp16_max(lb_rd[k*16 +: 16], hmax[k*16 +: 16]);
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    lb_we       = 1'b0;

    // A drain clears the output unless a fresh result overwrites it below.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (!col_q[0]) begin
        hold_d = bus.in_data;
      end else if (phase_q == StEven) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = vmax;
        out_last_d  = row_last && col_last;
      end

      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d   = '0;
          phase_d = StEven;
        end else begin
          row_d   = row_q + RW'(1);
          phase_d = (phase_q == StEven) ? StOdd : StEven;
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      phase_q     <= StEven;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer needs no reset: every entry is written on the even row before it is read.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[lb_idx] <= hmax;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed and random bench for maxpool2x2_stream using three parameterisations and
// per-instance scoreboards of {last, data} popped on each output handshake.
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  maxpool2x2_stream_if #(.CH(1)) s_if ();
  maxpool2x2_stream_if #(.CH(2)) n_if ();
  maxpool2x2_stream_if #(.CH(4)) b_if ();

  maxpool2x2_stream #(.IMG_W(4), .IMG_H(2), .CH(1)) u_small (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (s_if)
  );

  maxpool2x2_stream #(.IMG_W(2), .IMG_H(2), .CH(2)) u_neg (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (n_if)
  );

  maxpool2x2_stream #(.IMG_W(24), .IMG_H(24), .CH(4)) u_big (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [16:0] s_q [$];
  logic [32:0] n_q [$];
  logic [64:0] b_q [$];
  int          n_out_total = 0;
  int          b_out_total = 0;

  logic [15:0] small_px [8];
  logic [63:0] frm [576];

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent FP16 max: sign first, then magnitude with direction set by the sign.
  function automatic logic [15:0] m16(input logic [15:0] a, input logic [15:0] b);
    if (a[15] != b[15]) return a[15] ? b : a;
    if (!a[15]) return (a[14:0] >= b[14:0]) ? a : b;
    return (a[14:0] <= b[14:0]) ? a : b;
  endfunction

  function automatic logic [15:0] rand_fp16();
    logic [15:0] v;
    v = 16'($urandom);
    if (v[14:10] == 5'h1f) v[14] = 1'b0;
    return v;
  endfunction

  task automatic gen_frame();
    for (int p = 0; p < 576; p++) begin
      frm[p] = {rand_fp16(), rand_fp16(), rand_fp16(), rand_fp16()};
    end
  endtask

  task automatic push_frame();
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 12; c++) begin
        logic [63:0] e;
        int          i0;
        i0 = (2 * r) * 24 + 2 * c;
        for (int k = 0; k < 4; k++) begin
          e[k*16 +: 16] = m16(m16(frm[i0][k*16 +: 16], frm[i0+1][k*16 +: 16]),
                              m16(frm[i0+24][k*16 +: 16], frm[i0+25][k*16 +: 16]));
        end
        b_q.push_back({(r == 11 && c == 11), e});
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the last beat's accepting edge.
  task automatic drive_beats(input int n, output int stalls);
    stalls = 0;
    for (int p = 0; p < n; p++) begin
      b_if.in_data  = frm[p];
      b_if.in_valid = 1'b1;
      @(negedge clk);
      if (!b_if.in_ready) stalls++;
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && s_if.out_valid && s_if.out_ready) begin
      if (s_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL small_extra got=%h exp=none", {s_if.out_last, s_if.out_data});
      end else begin
        chk("small_out", 65'({s_if.out_last, s_if.out_data}), 65'(s_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && n_if.out_valid && n_if.out_ready) begin
      n_out_total++;
      if (n_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL neg_extra got=%h exp=none", {n_if.out_last, n_if.out_data});
      end else begin
        chk("neg_out", 65'({n_if.out_last, n_if.out_data}), 65'(n_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_if.out_valid && b_if.out_ready) begin
      b_out_total++;
      if (b_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL big_extra got=%h exp=none", {b_if.out_last, b_if.out_data});
      end else begin
        chk("big_out", {b_if.out_last, b_if.out_data}, b_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stalls;
    int base;

    small_px = '{16'h3C00, 16'h4000, 16'h3800, 16'hBC00,
                 16'hBC00, 16'h3C00, 16'h4200, 16'h3800};

    // Reset with a beat already presented.
    rst_n          = 1'b0;
    s_if.in_valid  = 1'b1;
    s_if.in_data   = small_px[0];
    s_if.out_ready = 1'b1;
    n_if.in_valid  = 1'b0;
    n_if.in_data   = '0;
    n_if.out_ready = 1'b1;
    b_if.in_valid  = 1'b1;
    b_if.in_data   = 64'h1234_5678_9ABC_DEF0;
    b_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_small_valid", 65'(s_if.out_valid), 65'(0));
    chk("rst_small_last", 65'(s_if.out_last), 65'(0));
    chk("rst_small_ready", 65'(s_if.in_ready), 65'(1));
    chk("rst_big_valid", 65'(b_if.out_valid), 65'(0));
    chk("rst_big_data", 65'(b_if.out_data), 65'(0));
    chk("rst_neg_last", 65'(n_if.out_last), 65'(0));
    b_if.in_valid = 1'b0;
    s_q.push_back({1'b0, 16'h4000});
    s_q.push_back({1'b1, 16'h4200});
    #2 rst_n = 1'b1;

    // 4x2 frame, back-to-back, output one cycle after each odd-row pair.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (i < 7) s_if.in_data = small_px[i+1];
      else s_if.in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("small_lat_%0d", i), 65'(s_if.out_valid), 65'((i == 5 || i == 7) ? 1 : 0));
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("small_drained", 65'(s_if.out_valid), 65'(0));
    chk("small_q_empty", 65'(s_q.size()), 65'(0));

    // Backpressure on a second frame of the same pixels.
    @(posedge clk);
    #1;
    s_q.push_back({1'b0, 16'h4000});
    s_q.push_back({1'b1, 16'h4200});
    s_if.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_if.in_data  = small_px[i];
      s_if.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    s_if.in_data = small_px[6];
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bp_in_ready", 65'(s_if.in_ready), 65'(0));
      chk("bp_valid", 65'(s_if.out_valid), 65'(1));
      chk("bp_data", 65'(s_if.out_data), 65'(16'h4000));
      @(posedge clk);
      #1;
    end
    s_if.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 65'(s_if.in_ready), 65'(1));
    @(posedge clk);
    #1;
    s_if.in_data = small_px[7];
    @(posedge clk);
    #1;
    s_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_q_empty", 65'(s_q.size()), 65'(0));

    // Negative values and independent lanes, CH=2.
    n_q.push_back({1'b1, 16'h3800, 16'hBC00});
    n_if.in_valid = 1'b1;
    n_if.in_data  = {16'h0000, 16'hBC00};
    @(posedge clk);
    #1;
    n_if.in_data = {16'h8000, 16'hC000};
    @(posedge clk);
    #1;
    n_if.in_data = {16'hBC00, 16'hC200};
    @(posedge clk);
    #1;
    n_if.in_data = {16'h3800, 16'hBE00};
    @(posedge clk);
    #1;
    n_if.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("neg_count", 65'(n_out_total), 65'(1));
    chk("neg_q_empty", 65'(n_q.size()), 65'(0));

    // Two random 24x24 frames streamed with no gap.
    base = b_out_total;
    for (int f = 0; f < 2; f++) begin
      gen_frame();
      push_frame();
      drive_beats(576, stalls);
      chk($sformatf("big_stalls_f%0d", f), 65'(stalls), 65'(0));
    end
    b_if.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("big_count", 65'(b_out_total - base), 65'(288));
    chk("big_q_empty", 65'(b_q.size()), 65'(0));

    // Reset in row 1 while a result is pending.
    b_if.out_ready = 1'b0;
    gen_frame();
    drive_beats(26, stalls);
    b_if.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_pending", 65'(b_if.out_valid), 65'(1));
    chk("mid_stall", 65'(b_if.in_ready), 65'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 65'(b_if.out_valid), 65'(0));
    chk("mid_rst_last", 65'(b_if.out_last), 65'(0));
    chk("mid_rst_data", 65'(b_if.out_data), 65'(0));
    b_q.delete();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    b_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    base = b_out_total;
    gen_frame();
    push_frame();
    drive_beats(576, stalls);
    b_if.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_count", 65'(b_out_total - base), 65'(144));
    chk("post_rst_q_empty", 65'(b_q.size()), 65'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
